// File: rtl/nonrestoring_divider_if.sv
// Handshake and result bundle between the issuing logic and the divider.
interface nonrestoring_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock,
// with the shared two's-complement adder as its add/subtract datapath.
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  nonrestoring_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_sum;
  logic             sub;

  // RUN subtracts while R is non-negative; FIX always adds D back (used only if R < 0).
  always_comb begin
    sub   = 1'b0;
    add_a = r;
    if (state == RUN) begin
      sub   = ~r[WIDTH];
      add_a = {r[WIDTH-1:0], q[WIDTH-1]};
    end
    add_b = sub ? ~{1'b0, d} : {1'b0, d};
  end

  adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (sub),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      r               <= '0;
      q               <= '0;
      d               <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              r        <= '0;
              q        <= bus.dividend;
              d        <= bus.divisor;
              cnt      <= CW'(WIDTH);
              bus.busy <= 1'b1;
              state    <= RUN;
            end else begin
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end
          end
        end
        RUN: begin
          r   <= add_sum;
          q   <= {q[WIDTH-2:0], ~add_sum[WIDTH]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (r[WIDTH]) r <= add_sum;
          bus.quotient    <= q;
          bus.remainder   <= r[WIDTH] ? add_sum[WIDTH-1:0] : r[WIDTH-1:0];
          bus.div_by_zero <= 1'b0;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// Wrap-around two's-complement adder: sum = a + b + cin, modulo 2**WIDTH.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  always_comb sum = a + b + {{(WIDTH-1){1'b0}}, cin};
endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
Sequential unsigned integer divider built on one (WIDTH+1)-bit instance of the team's signed adder, used as the add/subtract datapath. A control FSM sequences one quotient bit per clock. A start/busy/done handshake connects it to the issuing logic upstream. The final quotient and remainder stay on the outputs for the consumer downstream.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (WIDTH >= 2)

Ports:
clk  input  1  system clock, all state updates on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; sampled in the cycle start is accepted
divisor  input  WIDTH  unsigned divisor; sampled in the cycle start is accepted
busy  output  1  high from the cycle after acceptance until done is asserted
done  output  1  one-cycle pulse; result valid in this cycle and held afterwards
quotient  output  WIDTH  final quotient
remainder  output  WIDTH  final remainder
div_by_zero  output  1  set with done when divisor was 0; held with the result

Behaviour:
- Reset: synchronous, single cycle, active-high; dominates every other input.
  - FSM goes to IDLE.
  - busy, done, div_by_zero, quotient and remainder all go to 0.
  - Internal registers R, Q, D and the step counter all clear to 0.
- Datapath registers:
  - R: (WIDTH+1)-bit signed partial remainder.
  - Q: WIDTH-bit dividend/quotient shift register.
  - D: WIDTH-bit latched divisor.
  - Step counter: clog2(WIDTH+1) bits.
- Adder use: adder #(WIDTH+1), one instance.
  - Subtract: b = ~{1'b0,D}, cin = 1.
  - Add: b = {1'b0,D}, cin = 0.
  - a is the shifted partial remainder (RUN) or R (FIX).
  - Sum is wrap-around, two's complement, WIDTH+1 bits.
- FSM IDLE:
  - start=1 and divisor!=0: R<=0, Q<=dividend, D<=divisor, counter<=WIDTH, busy<=1, go to RUN.
  - start=1 and divisor==0: go to DONE with quotient<={WIDTH{1'b1}}, remainder<=dividend, div_by_zero<=1. busy stays 0 throughout.
  - start=0: stay in IDLE, outputs hold their last result.
- FSM RUN, one step per cycle, exactly WIDTH cycles:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If R >= 0 (R[WIDTH]==0), R <= S - D; otherwise R <= S + D.
  - Q <= {Q[WIDTH-2:0], ~Rnew[WIDTH]}.
  - Decrement the counter. When the counter reaches 1, go to FIX.
- FSM FIX, one cycle:
  - If R < 0, R <= R + D; otherwise R is unchanged.
  - quotient <= Q, remainder <= corrected R[WIDTH-1:0], div_by_zero <= 0.
  - Go to DONE.
- FSM DONE, one cycle: done=1, busy=0, then go to IDLE.
- Latency, with start accepted at edge 0:
  - RUN occupies edges 1..WIDTH; FIX occupies edge WIDTH+1.
  - done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles after acceptance.
  - Divide-by-zero: done is high in the cycle after edge 0 (1 cycle).
- Handshake rules:
  - start while busy, or in the DONE cycle, is ignored; the operands are not re-sampled.
  - start in the first IDLE cycle after done is accepted, so back-to-back operations cost WIDTH+3 cycles each.
- Result registers update only in FIX or on the divide-by-zero path. Intermediate states are never visible on quotient or remainder.
- Invariants on a completed division: dividend == quotient*divisor + remainder, and remainder < divisor.
- Reset asserted mid-RUN or mid-FIX aborts the operation: no done pulse, all outputs 0 on the next cycle.

Test Plan:
- WIDTH=8; reset, then 100/7 -> busy high for 9 cycles; done exactly 10 cycles after start with quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. Then 5/9 -> quotient=0, remainder=5. Then 255/255 -> quotient=1, remainder=0. Issue these back-to-back with start held high; consecutive done pulses are 11 cycles apart.
- 200/0 -> done 1 cycle after start, quotient=255, remainder=200, div_by_zero=1, busy never high. A following 9/4 -> quotient=2, remainder=1, div_by_zero=0.
- Start 100/7, then pulse start with 50/5 on cycle 3 -> the second request is ignored and the result is 14 r 2.
- Start 100/7, assert rst at cycle 5 -> no done; all outputs 0 the next cycle. A new 17/3 after reset -> quotient=5, remainder=2.
- Random sweep, 2000 vectors, WIDTH=8 and WIDTH=4 -> every result matches the integer reference model. done is one cycle wide, and outputs are stable between done pulses.
